// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM optical link (transmitter pwm and receiver pwm_demod).
package pwm_pkg;

  localparam int unsigned PWM_PERIOD = 8;
  localparam int unsigned PWM_SYM_W  = 2;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } demod_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit; resets to 0.
module sync_2ff (
  input  logic aclk,
  input  logic aresetn,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops to let metastability resolve before use.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pwm_demod.sv
// PWM symbol demodulator: recovers SYM_W-bit symbols from fixed-length frames
// whose low phase length encodes the symbol. Strobes and lock are registered.
// Optional macro PWM_DEMOD_SYNC_EN inserts a 2-flop synchroniser on pwm_in.
module pwm_demod
  import pwm_pkg::*;
#(
  parameter int unsigned PERIOD = PWM_PERIOD,
  parameter int unsigned SYM_W  = PWM_SYM_W
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             pwm_in,
  output logic [SYM_W-1:0] sym_out,
  output logic             sym_valid,
  output logic             sym_err,
  output logic             locked
);

  localparam int unsigned MAX_LVL = (1 << SYM_W) - 1;
  localparam int unsigned POS_W   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int unsigned RUN_W   = $clog2(PERIOD + 1);

  localparam logic [POS_W-1:0] LAST_POS = POS_W'(PERIOD - 1);
  localparam logic [RUN_W-1:0] RUN_SAT  = RUN_W'(PERIOD);
  localparam logic [RUN_W-1:0] RUN_LVL  = RUN_W'(MAX_LVL);

  logic             line;
  logic             s;
  logic             s_d;
  logic             fall;
  logic             rise;
  demod_state_e     state;
  demod_state_e     state_nxt;
  logic [POS_W-1:0] fpos;
  logic [POS_W-1:0] fpos_nxt;
  logic [POS_W-1:0] fpos_wrap;
  logic [RUN_W-1:0] run;
  logic [RUN_W-1:0] run_nxt;
  logic [RUN_W-1:0] run_inc;
  logic [SYM_W-1:0] sym_nxt;
  logic             valid_nxt;
  logic             err_nxt;
  logic             locked_nxt;

`ifdef PWM_DEMOD_SYNC_EN
  sync_2ff u_sync (
    .aclk    (aclk),
    .aresetn (aresetn),
    .d       (pwm_in),
    .q       (line)
  );
`else
  assign line = pwm_in;
`endif

  assign fall      = s_d & ~s;
  assign rise      = ~s_d & s;
  assign fpos_wrap = (fpos == LAST_POS) ? '0 : fpos + 1'b1;
  assign run_inc   = (run == RUN_SAT) ? run : run + 1'b1;

  // Sample the line and keep the previous sample for edge detection.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s   <= 1'b0;
      s_d <= 1'b0;
    end else begin
      s   <= line;
      s_d <= s;
    end
  end

  // State, frame position, low-run counter and registered outputs.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= HUNT;
      fpos      <= '0;
      run       <= '0;
      sym_out   <= '0;
      sym_valid <= 1'b0;
      sym_err   <= 1'b0;
      locked    <= 1'b0;
    end else begin
      state     <= state_nxt;
      fpos      <= fpos_nxt;
      run       <= run_nxt;
      sym_out   <= sym_nxt;
      sym_valid <= valid_nxt;
      sym_err   <= err_nxt;
      locked    <= locked_nxt;
    end
  end

  // Next-state decode; fpos_wrap is the frame position of the current sample.
  always_comb begin
    state_nxt  = state;
    fpos_nxt   = fpos_wrap;
    run_nxt    = run;
    sym_nxt    = sym_out;
    valid_nxt  = 1'b0;
    err_nxt    = 1'b0;
    locked_nxt = locked;
    unique case (state)
      HUNT: begin
        if (fall) begin
          state_nxt = LOW;
          fpos_nxt  = '0;
          run_nxt   = RUN_W'(1);
        end
      end
      LOW: begin
        if (!s) begin
          run_nxt = run_inc;
          if (run_inc == RUN_SAT) begin
            err_nxt    = 1'b1;
            locked_nxt = 1'b0;
            state_nxt  = HUNT;
          end
        end else if (rise) begin
          if ((run != '0) && (run <= RUN_LVL)) begin
            sym_nxt    = SYM_W'(run);
            valid_nxt  = 1'b1;
            locked_nxt = 1'b1;
          end else begin
            err_nxt    = 1'b1;
            locked_nxt = 1'b0;
          end
          state_nxt = HIGH;
        end
      end
      HIGH: begin
        if (fall) begin
          // An early falling edge is flagged but still taken as the new frame start.
          if (fpos_wrap != '0) begin
            err_nxt    = 1'b1;
            locked_nxt = 1'b0;
          end
          state_nxt = LOW;
          fpos_nxt  = '0;
          run_nxt   = RUN_W'(1);
        end else if (s && (fpos_wrap == '0)) begin
          sym_nxt   = '0;
          valid_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = HUNT;
      end
    endcase
  end

endmodule

// File: tb/tb_pwm_demod.sv
// Directed self-checking bench for pwm_demod. Every strobe is logged as a code
// built from the index of the line sample that caused it, its kind, sym_out
// and locked; each test compares the log with hand-computed expectations.
module tb_pwm_demod;

`ifdef PWM_DEMOD_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic       aclk    = 1'b0;
  logic       aresetn = 1'b1;
  logic       pwm_in  = 1'b1;
  logic [1:0] sym_out;
  logic       sym_valid;
  logic       sym_err;
  logic       locked;

  int total = 0;
  int bad   = 0;
  int t     = 0;
  int base  = 0;
  int ev_q[$];
  int exp_q[$];

  pwm_demod #(.PERIOD(8), .SYM_W(2)) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .pwm_in    (pwm_in),
    .sym_out   (sym_out),
    .sym_valid (sym_valid),
    .sym_err   (sym_err),
    .locked    (locked)
  );

  always #5 aclk = ~aclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Event code: kind 1 = valid, 2 = err, 3 = both.
  function automatic int ev(int idx, int kind, int sym, int lk);
    return idx * 1000 + kind * 100 + sym * 10 + lk;
  endfunction

  // One cycle: sample outputs at the falling edge, then drive the next line sample.
  task automatic tick(input logic v);
    @(negedge aclk);
    total++;
    if (sym_valid === 1'b1 && sym_err === 1'b1) begin
      bad++;
      $display("FAIL strobe_excl t=%0d valid=%b err=%b required not both high", t, sym_valid, sym_err);
    end
    if (sym_valid === 1'b1 || sym_err === 1'b1)
      ev_q.push_back(ev(t - LAT - base, int'({sym_err, sym_valid}), int'(sym_out), int'(locked)));
    pwm_in = v;
    t++;
  endtask

  task automatic send_frame(input int lvl);
    for (int i = 0; i < 8; i++) tick((i < lvl) ? 1'b0 : 1'b1);
  endtask

  task automatic flush();
    repeat (LAT) tick(1'b1);
  endtask

  task automatic reset_dut();
    @(negedge aclk);
    pwm_in  = 1'b1;
    aresetn = 1'b0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    repeat (6) tick(1'b1);
    ev_q.delete();
    base = t;
  endtask

  task automatic test_reset();
    int got;
    @(negedge aclk);
    pwm_in  = 1'b1;
    aresetn = 1'b0;
    #1;
    total++; if (sym_out !== 2'd0)  begin bad++; $display("FAIL rst_sym_out got=%0d exp=0", sym_out); end
    total++; if (sym_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", sym_valid); end
    total++; if (sym_err !== 1'b0)  begin bad++; $display("FAIL rst_err got=%b exp=0", sym_err); end
    total++; if (locked !== 1'b0)   begin bad++; $display("FAIL rst_locked got=%b exp=0", locked); end
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    base = t;
    repeat (20) tick(1'b1);
    flush();
    total++;
    if (ev_q.size() != 0) begin
      got = ev_q[0];
      bad++;
      $display("FAIL hold_high_strobes got=%0d first=%0d exp=0 strobes", ev_q.size(), got);
    end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL hold_high_locked got=%b exp=0", locked); end
  endtask

  task automatic test_sym2_stream();
    int got;
    reset_dut();
    repeat (4) send_frame(2);
    flush();
    exp_q = '{ev(2,1,2,1), ev(10,1,2,1), ev(18,1,2,1), ev(26,1,2,1)};
    total++;
    if (ev_q.size() != exp_q.size()) begin
      bad++; $display("FAIL sym2_count got=%0d exp=%0d", ev_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      got = (i < ev_q.size()) ? ev_q[i] : -1;
      total++;
      if (got !== exp_q[i]) begin bad++; $display("FAIL sym2_ev[%0d] got=%0d exp=%0d", i, got, exp_q[i]); end
    end
  endtask

  task automatic test_sequence();
    int got;
    int syms[5] = '{1, 3, 0, 0, 2};
    reset_dut();
    foreach (syms[k]) send_frame(syms[k]);
    flush();
    exp_q = '{ev(1,1,1,1), ev(11,1,3,1), ev(16,1,0,1), ev(24,1,0,1), ev(34,1,2,1)};
    total++;
    if (ev_q.size() != exp_q.size()) begin
      bad++; $display("FAIL seq_count got=%0d exp=%0d", ev_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      got = (i < ev_q.size()) ? ev_q[i] : -1;
      total++;
      if (got !== exp_q[i]) begin bad++; $display("FAIL seq_ev[%0d] got=%0d exp=%0d", i, got, exp_q[i]); end
    end
  endtask

  task automatic test_long_low_phase();
    int got;
    reset_dut();
    send_frame(2);
    send_frame(5);
    send_frame(1);
    flush();
    exp_q = '{ev(2,1,2,1), ev(13,2,2,0), ev(17,1,1,1)};
    total++;
    if (ev_q.size() != exp_q.size()) begin
      bad++; $display("FAIL len_err_count got=%0d exp=%0d", ev_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      got = (i < ev_q.size()) ? ev_q[i] : -1;
      total++;
      if (got !== exp_q[i]) begin bad++; $display("FAIL len_err_ev[%0d] got=%0d exp=%0d", i, got, exp_q[i]); end
    end
  endtask

  task automatic test_realign();
    int got;
    reset_dut();
    send_frame(1);
    send_frame(0);
    repeat (5) tick(1'b1);
    tick(1'b0);
    repeat (18) tick(1'b1);
    flush();
    exp_q = '{ev(1,1,1,1), ev(8,1,0,1), ev(16,1,0,1), ev(21,2,0,0),
              ev(22,1,1,1), ev(29,1,0,1), ev(37,1,0,1)};
    total++;
    if (ev_q.size() != exp_q.size()) begin
      bad++; $display("FAIL realign_count got=%0d exp=%0d", ev_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      got = (i < ev_q.size()) ? ev_q[i] : -1;
      total++;
      if (got !== exp_q[i]) begin bad++; $display("FAIL realign_ev[%0d] got=%0d exp=%0d", i, got, exp_q[i]); end
    end
  endtask

  task automatic test_stuck_low();
    int got;
    reset_dut();
    send_frame(2);
    repeat (8) tick(1'b0);
    repeat (8) tick(1'b1);
    send_frame(3);
    flush();
    exp_q = '{ev(2,1,2,1), ev(15,2,2,0), ev(27,1,3,1)};
    total++;
    if (ev_q.size() != exp_q.size()) begin
      bad++; $display("FAIL stuck_count got=%0d exp=%0d", ev_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      got = (i < ev_q.size()) ? ev_q[i] : -1;
      total++;
      if (got !== exp_q[i]) begin bad++; $display("FAIL stuck_ev[%0d] got=%0d exp=%0d", i, got, exp_q[i]); end
    end
  endtask

  task automatic test_mid_reset();
    int got;
    reset_dut();
    send_frame(2);
    repeat (6) tick(1'b1);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL pre_rst_locked got=%b exp=1", locked); end
    #2 aresetn = 1'b0;
    #1;
    total++; if (sym_out !== 2'd0)  begin bad++; $display("FAIL mid_rst_sym_out got=%0d exp=0", sym_out); end
    total++; if (sym_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b exp=0", sym_valid); end
    total++; if (sym_err !== 1'b0)  begin bad++; $display("FAIL mid_rst_err got=%b exp=0", sym_err); end
    total++; if (locked !== 1'b0)   begin bad++; $display("FAIL mid_rst_locked got=%b exp=0", locked); end
    tick(1'b1);
    tick(1'b1);
    aresetn = 1'b1;
    repeat (8) tick(1'b1);
    send_frame(1);
    flush();
    exp_q = '{ev(2,1,2,1), ev(8,1,0,1), ev(25,1,1,1)};
    total++;
    if (ev_q.size() != exp_q.size()) begin
      bad++; $display("FAIL mid_rst_count got=%0d exp=%0d", ev_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      got = (i < ev_q.size()) ? ev_q[i] : -1;
      total++;
      if (got !== exp_q[i]) begin bad++; $display("FAIL mid_rst_ev[%0d] got=%0d exp=%0d", i, got, exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_sym2_stream();
    test_sequence();
    test_long_low_phase();
    test_realign();
    test_stuck_low();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
